// File: rtl/multi_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_shift_pkg
// Description : Shared constants and state encoding for multi_shift_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_shift_pkg;

    localparam int c_data_w   = 8;
    localparam int c_amt_w    = 5;
    localparam int c_passes_w = 3;
    localparam int c_max_step = 7;
    localparam int c_step_w   = 3;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/multi_shift_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_shift_if
// Description : Request/result handshake bundle for multi_shift_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_shift_if
    import multi_shift_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int AMT_W  = c_amt_w
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [AMT_W-1:0]      in_amt;
    logic                  in_dir;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [c_passes_w-1:0] out_passes;
    logic                  busy;

    // Requester / consumer side
    modport master (
        output in_valid, in_data, in_amt, in_dir, out_ready,
        input  in_ready, out_valid, out_data, out_passes, busy
    );

    // Controller side
    modport slave (
        input  in_valid, in_data, in_amt, in_dir, out_ready,
        output in_ready, out_valid, out_data, out_passes, busy
    );
endinterface
`default_nettype wire

// File: rtl/multi_shift_ctrl_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shifter
// Description : Combinational logical shifter, zero fill; dir=1 left, 0 right.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shifter #(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = 3
) (
    input  logic [DATA_W-1:0]  in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    output logic [DATA_W-1:0]  out
);
    assign out = dir ? (in << shamt) : (in >> shamt);
endmodule
`default_nettype wire

// File: rtl/multi_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_shift_ctrl
// Description : Splits shift requests of up to 31 positions into passes of at
//               most 7 through one barrel_shifter. Optional macro
//               MULTI_SHIFT_SATURATE_EN short-circuits amounts >= DATA_W.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_shift_ctrl
    import multi_shift_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int AMT_W  = c_amt_w
) (
    input  logic         clk,
    input  logic         rst_n,
    multi_shift_if.slave bus
);
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_W-1:0]     r_work;
    logic [AMT_W-1:0]      r_remaining;
    logic                  r_dir;
    logic [c_passes_w-1:0] r_passes;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [DATA_W-1:0]     r_out_data;
    logic [c_passes_w-1:0] r_out_passes;

    logic                  w_last;
    logic [c_step_w-1:0]   w_step;
    logic [DATA_W-1:0]     w_shift_out;
    logic                  w_amt_zero;
    logic                  w_sat;

    assign w_last     = (r_remaining <= AMT_W'(c_max_step));
    assign w_step     = w_last ? r_remaining[c_step_w-1:0] : c_step_w'(c_max_step);
    assign w_amt_zero = (bus.in_amt == '0);

`ifdef MULTI_SHIFT_SATURATE_EN
    assign w_sat = (32'(bus.in_amt) >= DATA_W);
`else
    assign w_sat = 1'b0;
`endif

    barrel_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (c_step_w)
    ) u_barrel_shifter (
        .in    (r_work),
        .shamt (w_step),
        .dir   (r_dir),
        .out   (w_shift_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (bus.in_valid) w_state_nxt = (w_amt_zero || w_sat) ? c_st_done : c_st_shift;
            c_st_shift: if (w_last)       w_state_nxt = c_st_done;
            c_st_done:  if (bus.out_ready) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Handshake flags are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == c_st_done);
            r_busy      <= (w_state_nxt != c_st_idle);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work       <= '0;
            r_remaining  <= '0;
            r_dir        <= 1'b0;
            r_passes     <= '0;
            r_out_data   <= '0;
            r_out_passes <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.in_valid) begin
                        r_work      <= bus.in_data;
                        r_remaining <= bus.in_amt;
                        r_dir       <= bus.in_dir;
                        r_passes    <= '0;
                        if (w_sat) begin
                            r_out_data   <= '0;
                            r_out_passes <= '0;
                        end else if (w_amt_zero) begin
                            r_out_data   <= bus.in_data;
                            r_out_passes <= '0;
                        end
                    end
                end
                c_st_shift: begin
                    r_work      <= w_shift_out;
                    r_remaining <= r_remaining - AMT_W'(w_step);
                    r_passes    <= r_passes + c_passes_w'(1);
                    if (w_last) begin
                        r_out_data   <= w_shift_out;
                        r_out_passes <= r_passes + c_passes_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == c_st_idle);
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = r_busy;
    assign bus.out_data   = r_out_data;
    assign bus.out_passes = r_out_passes;
endmodule
`default_nettype wire
